// File: rtl/histogram_builder_if.sv
// histogram_builder_if: pixel stream, display read port and published results
// of the frame histogram builder. Clock and reset stay outside as plain ports.
interface histogram_builder_if #(
    parameter int BIN_W = 20
);
    logic             iFrameStart;
    logic             iFrameEnd;
    logic             iValid;
    logic [7:0]       iPixel;
    logic [7:0]       iHistoAddr;
    logic [BIN_W-1:0] oHistoData;
    logic [BIN_W-1:0] oMaxValue;
    logic [7:0]       oThreshPoint25;
    logic [7:0]       oThreshPoint50;
    logic [7:0]       oThreshPoint75;
    logic             oDone;
    logic             oOverrun;

    // camera / display side
    modport master (
        output iFrameStart, iFrameEnd, iValid, iPixel, iHistoAddr,
        input  oHistoData, oMaxValue, oThreshPoint25, oThreshPoint50,
               oThreshPoint75, oDone, oOverrun
    );

    // histogram builder side
    modport slave (
        input  iFrameStart, iFrameEnd, iValid, iPixel, iHistoAddr,
        output oHistoData, oMaxValue, oThreshPoint25, oThreshPoint50,
               oThreshPoint75, oDone, oOverrun
    );
endinterface

// File: rtl/histogram_builder.sv
// histogram_builder: per-frame 256-bin luminance histogram in a ping-pong bin
// RAM. The accumulate bank is cleared, filled by a forwarded 2-stage RMW, then
// scanned for the max bin and the 25/50/75 percentile bins, and finally swapped
// in as the display bank.
// Optional build macro HISTO_MAX_EXCLUDE_EXTREMES_EN: bins 0 and 255 do not
// take part in the oMaxValue search (they are still counted everywhere else).
module histogram_builder #(
    parameter int BIN_W    = 20,
    parameter int CLR_BINS = 256
) (
    input logic                iClk,
    input logic                iRst_n,
    histogram_builder_if.slave bus
);
    localparam int               CW        = BIN_W + 9;
    localparam logic [BIN_W-1:0] SAT       = '1;
    localparam logic [8:0]       CLR_LAST  = 9'(CLR_BINS - 1);
    localparam logic [8:0]       SCAN_LAST = 9'(CLR_BINS);

    typedef enum logic [2:0] {
        RST_CLR, IDLE, CLEAR, ACCUM, DRAIN, SCAN, PUBLISH
    } state_t;

    state_t           state, stateNxt;
    logic [8:0]       cnt;
    logic             dispBank;

    logic [BIN_W-1:0] mem0 [256];
    logic [BIN_W-1:0] mem1 [256];
    logic [BIN_W-1:0] accRd, histoData;

    logic             s1Vld, wrVld;
    logic [7:0]       s1Pix, wrPix;
    logic [BIN_W-1:0] wrData, nCnt;

    logic [CW-1:0]    cSum, cNext;
    logic [BIN_W-1:0] maxBin, maxQ;
    logic [7:0]       t25, t50, t75, thr25Q, thr50Q, thr75Q;
    logic             f25, f50, f75, doneQ, ovrQ;

    logic             accept, we0, we1, maxEligible, ovrSet;
    logic [7:0]       wa, accAddr, scanBin;
    logic [BIN_W-1:0] wd, rmwBase, rmwVal, q25, q50, q75;

    // state register; reset always restarts from the dual-bank clear
    always_ff @(posedge iClk) begin
        if (!iRst_n) state <= RST_CLR;
        else         state <= stateNxt;
    end

    // next-state logic
    always_comb begin
        stateNxt = state;
        case (state)
            RST_CLR: if (cnt == CLR_LAST)       stateNxt = IDLE;
            IDLE:    if (bus.iFrameStart)       stateNxt = CLEAR;
            CLEAR:   if (cnt == CLR_LAST)       stateNxt = ACCUM;
            ACCUM:   if (bus.iFrameEnd)         stateNxt = DRAIN;
            DRAIN:   if (cnt == 9'd1)           stateNxt = SCAN;
            SCAN:    if (cnt == SCAN_LAST)      stateNxt = PUBLISH;
            PUBLISH:                            stateNxt = IDLE;
            default:                            stateNxt = RST_CLR;
        endcase
    end

    // per-state cycle index: clear address, drain count and scan address
    always_ff @(posedge iClk) begin
        if (!iRst_n)                cnt <= '0;
        else if (stateNxt != state) cnt <= '0;
        else                        cnt <= cnt + 9'd1;
    end

    // RMW increment with forwarding of the write retired on the previous edge,
    // which the in-flight read could not yet observe
    always_comb begin
        accept  = (state == ACCUM) && bus.iValid;
        rmwBase = (wrVld && wrPix == s1Pix) ? wrData : accRd;
        rmwVal  = (rmwBase == SAT) ? SAT : rmwBase + BIN_W'(1);
        accAddr = (state == SCAN) ? cnt[7:0] : bus.iPixel;
        scanBin = cnt[7:0] - 8'd1;
        cNext   = cSum + CW'(accRd);
        q25     = nCnt >> 2;
        q50     = nCnt >> 1;
        q75     = q50 + q25;
`ifdef HISTO_MAX_EXCLUDE_EXTREMES_EN
        maxEligible = (scanBin != 8'd0) && (scanBin != 8'hFF);
`else
        maxEligible = 1'b1;
`endif
        ovrSet  = ((state == CLEAR) && bus.iValid) ||
                  (bus.iFrameStart && state != IDLE && state != RST_CLR);
    end

    // single bin-RAM write port: dual clear, bank clear or RMW write-back
    always_comb begin
        we0 = 1'b0;
        we1 = 1'b0;
        wa  = s1Pix;
        wd  = rmwVal;
        case (state)
            RST_CLR: begin
                we0 = 1'b1;
                we1 = 1'b1;
                wa  = cnt[7:0];
                wd  = '0;
            end
            CLEAR: begin
                we0 = dispBank;
                we1 = !dispBank;
                wa  = cnt[7:0];
                wd  = '0;
            end
            default: begin
                we0 = s1Vld && dispBank;
                we1 = s1Vld && !dispBank;
            end
        endcase
    end

    // bin RAM banks
    always_ff @(posedge iClk) begin
        if (we0) mem0[wa] <= wd;
        if (we1) mem1[wa] <= wd;
    end

    // registered reads: accumulate bank for RMW/scan, display bank for the port
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            accRd     <= '0;
            histoData <= '0;
        end else begin
            accRd     <= dispBank ? mem0[accAddr] : mem1[accAddr];
            histoData <= dispBank ? mem1[bus.iHistoAddr] : mem0[bus.iHistoAddr];
        end
    end

    // accumulate pipeline and saturating total pixel count
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            s1Vld  <= 1'b0;
            s1Pix  <= '0;
            wrVld  <= 1'b0;
            wrPix  <= '0;
            wrData <= '0;
            nCnt   <= '0;
        end else begin
            s1Vld  <= accept;
            s1Pix  <= bus.iPixel;
            wrVld  <= s1Vld;
            wrPix  <= s1Pix;
            wrData <= rmwVal;
            if (state == CLEAR)            nCnt <= '0;
            else if (accept && nCnt != SAT) nCnt <= nCnt + BIN_W'(1);
        end
    end

    // scan: running cumulative sum, max bin and first-crossing percentile bins
    always_ff @(posedge iClk) begin
        if (!iRst_n || state == DRAIN) begin
            cSum   <= '0;
            maxBin <= '0;
            {t25, t50, t75} <= '0;
            {f25, f50, f75} <= '0;
        end else if (state == SCAN && cnt != 9'd0) begin
            cSum <= cNext;
            if (maxEligible && accRd > maxBin) maxBin <= accRd;
            if (!f25 && cNext >= CW'(q25)) begin t25 <= scanBin; f25 <= 1'b1; end
            if (!f50 && cNext >= CW'(q50)) begin t50 <= scanBin; f50 <= 1'b1; end
            if (!f75 && cNext >= CW'(q75)) begin t75 <= scanBin; f75 <= 1'b1; end
        end
    end

    // publish results, swap banks, sticky overrun flag
    always_ff @(posedge iClk) begin
        if (!iRst_n) begin
            maxQ     <= '0;
            {thr25Q, thr50Q, thr75Q} <= '0;
            doneQ    <= 1'b0;
            ovrQ     <= 1'b0;
            dispBank <= 1'b0;
        end else begin
            doneQ <= 1'b0;
            if (ovrSet) ovrQ <= 1'b1;
            if (state == PUBLISH) begin
                maxQ     <= maxBin;
                thr25Q   <= t25;
                thr50Q   <= t50;
                thr75Q   <= t75;
                doneQ    <= 1'b1;
                dispBank <= !dispBank;
            end
        end
    end

    assign bus.oHistoData     = histoData;
    assign bus.oMaxValue      = maxQ;
    assign bus.oThreshPoint25 = thr25Q;
    assign bus.oThreshPoint50 = thr50Q;
    assign bus.oThreshPoint75 = thr75Q;
    assign bus.oDone          = doneQ;
    assign bus.oOverrun       = ovrQ;
endmodule
